or1200_vld_dp: RTL
==================

Name: or1200_vld_dp

Overview:
- Variable-length bit unpacker datapath for the OR1200 VLX unit. It is the read-side counterpart of the VLX bit packer.
- Fetches JPEG entropy-coded bytes from a byte source through a request/ack handshake. Removes stuffed 0x00 bytes that follow 0xFF, and stops fetching when it detects a marker (0xFF followed by a non-zero byte).
- Returns 1..16 bits per CPU get-bits instruction, MSB-first, and stalls the CPU while too few bits are buffered.
- Buffer state is visible to software through two SPRs.

Parameters:
- MAX_READ, 16, maximum bits returned by one get-bits operation. Legal values are 1..24.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- byte_i  in  8  incoming stream byte; valid only in a cycle where ack_i=1.
- ack_i  in  1  one-cycle pulse: byte_i delivered; the request is complete.
- need_byte_o  out  1  byte request; held high until ack_i.
- get_bit_op_i  in  1  CPU get-bits operation is active this cycle.
- num_bits_to_read_i  in  5  number of bits requested (n); 0 means no-op.
- bit_vector_o  out  32  requested bits, right-justified, zero-extended.
- stall_CPU_o  out  1  CPU must hold the current instruction.
- spr_addr  in  1  SPR select: 0 = bit count, 1 = bit buffer.
- write_dp_spr_i  in  1  SPR write strobe.
- spr_dat_i  in  32  SPR write data.
- spr_dat_o  out  32  SPR read data: spr_addr ? bit_reg : {25'b0, marker, bit_cnt[5:0]}.
- marker_o  out  1  a marker has been detected; fetching is halted.
- marker_byte_o  out  8  second byte of the detected marker.

Behaviour:
- State:
  - bit_reg[31:0]: valid bits occupy the low bit_cnt positions; the newest byte sits at the LSBs.
  - bit_cnt[5:0]: number of valid bits, range 0..32.
- Reset values: bit_reg=0, bit_cnt=0, marker=0, marker_byte_o=0, FSM in IDLE, need_byte_o=0, stall_CPU_o=0, bit_vector_o=0.
- Append (a byte is accepted as data):
  - bit_reg <= {bit_reg[23:0], byte}; bit_cnt += 8.
  - The byte is usable from the next cycle.
- Read, combinational in the same cycle:
  - If get_bit_op_i=1 and 0 < n <= bit_cnt: bit_vector_o = (bit_reg >> (bit_cnt-n)) & ((1<<n)-1); stall_CPU_o=0; bit_cnt -= n at the clock edge.
  - bit_reg is not modified by a read.
  - If n > bit_cnt and marker=0: stall_CPU_o=1; bit_vector_o=0; no state change. Retry every cycle until enough bits are buffered.
  - If n > bit_cnt and marker=1: no stall. The available bits are returned left-justified within n and padded with 1s in the low positions; bit_cnt <= 0.
  - If n=0 or get_bit_op_i=0: bit_vector_o=0, stall_CPU_o=0.
  - If n > MAX_READ: n is treated as MAX_READ.
- Same-cycle read and append: the read is computed from pre-edge bit_reg/bit_cnt. Then bit_cnt_next = bit_cnt - n + 8 and bit_reg shifts as in an append.
- Fetch FSM states: IDLE, FETCH, FETCH_STUFF, MARKER.
  - IDLE: if bit_cnt_next <= 24 and marker=0, go to FETCH with need_byte_o=1 from the next cycle.
  - FETCH: need_byte_o=1.
    - On ack_i with byte != 0xFF: append the byte; go to IDLE.
    - On ack_i with byte == 0xFF: hold 0xFF in the pending register without appending it; go to FETCH_STUFF.
  - FETCH_STUFF: need_byte_o=1.
    - On ack_i with byte == 0x00: append 0xFF and discard the 0x00; go to IDLE.
    - On ack_i with byte != 0x00: drop the pending 0xFF; marker<=1; marker_byte_o<=byte; go to MARKER.
  - MARKER: need_byte_o=0. Stays in MARKER until a flush.
- The fetch condition is never true when bit_cnt > 24, so an append can never overflow 32 bits.
- need_byte_o drops in the cycle after ack_i; it never re-requests in the ack cycle itself.
- SPR writes (write_dp_spr_i=1):
  - spr_addr=1: bit_reg <= spr_dat_i.
  - spr_addr=0: bit_cnt <= spr_dat_i[5:0], with values above 32 clamped to 32.
  - spr_addr=0 with spr_dat_i[31]=1: flush. Additionally marker<=0, marker_byte_o<=0, pending 0xFF discarded, FSM to IDLE.
  - An SPR write has priority over a same-cycle read or append. A byte acked in that cycle is discarded; software issues SPR writes only at segment boundaries.
  - A get-bits operation in the same cycle as an SPR write is stalled for one cycle.
- Reset mid-fetch: the FSM returns to IDLE and need_byte_o drops on the next edge. An ack_i in the reset cycle is ignored.

Test Plan:
- Basic unpack: after reset, feed 0xA5 then 0x3C, each acked 1 cycle after request. Read n=4 → 0xA; read n=8 → 0x53; read n=4 → 0xC; bit_cnt=0; no stalls.
- Unstuffing: feed 0xFF, 0x00, 0x12. Read n=16 → 0xFF12; bit_cnt=0; marker_o=0.
- Marker with padding: feed 0xAB, 0xFF, 0xD9. Read n=8 → 0xAB; then marker_o=1, marker_byte_o=0xD9, need_byte_o stays 0. Read n=4 → 0xF with no stall; bit_cnt=0.
- Stall: start empty and issue read n=12 with ack_i 3 cycles after each request, bytes 0x12 and 0x34. stall_CPU_o stays high until the cycle after the second append, then bit_vector_o=0x123 and bit_cnt=4.
- Boundary: with bit_cnt=24, a read n=5 coincides with ack_i for byte 0x80. bit_cnt becomes 27, the read value comes from the old bits, and need_byte_o is not reasserted.
- Reset/flush: assert rst_i while need_byte_o=1 → all outputs at reset values next cycle. From MARKER, SPR write spr_addr=0, data=0x80000000 → marker_o=0, bit_cnt=0, and need_byte_o=1 again within 2 cycles.

Source files
------------

// File: rtl/or1200_vld_dp.sv
// ---------------------------------------------------------------------------
// or1200_vld_dp
// Variable-length bit unpacker datapath for the OR1200 VLX unit. This is the
// read-side counterpart of the VLX bit packer. It pulls JPEG entropy-coded
// bytes from a byte source, removes the 0x00 stuffed after every 0xFF, stops
// fetching once a marker (0xFF followed by a non-zero byte) appears, and hands
// 1..MAX_READ bits per get-bits instruction to the CPU, MSB-first.
//
// Ports:
//   clk_i              clock, all state changes on the rising edge
//   rst_i              synchronous active-high reset
//   byte_i / ack_i     byte source data / one-cycle delivery pulse
//   need_byte_o        byte request, held until ack_i
//   get_bit_op_i       CPU get-bits operation active this cycle
//   num_bits_to_read_i number of bits requested (0 = no-op)
//   bit_vector_o       requested bits, right-justified, zero-extended
//   stall_CPU_o        CPU must hold the current instruction
//   spr_addr           SPR select: 0 = bit count/marker, 1 = bit buffer
//   write_dp_spr_i     SPR write strobe
//   spr_dat_i/o        SPR write / read data
//   marker_o           marker detected, fetching halted
//   marker_byte_o      second byte of the detected marker
// ---------------------------------------------------------------------------
module or1200_vld_dp #(
    parameter int MAX_READ = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_i,
    input  logic        ack_i,
    output logic        need_byte_o,
    input  logic        get_bit_op_i,
    input  logic [4:0]  num_bits_to_read_i,
    output logic [31:0] bit_vector_o,
    output logic        stall_CPU_o,
    input  logic        spr_addr,
    input  logic        write_dp_spr_i,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o,
    output logic        marker_o,
    output logic [7:0]  marker_byte_o
);

    localparam logic [5:0] MAX_READ_C = 6'(MAX_READ);

    // FETCH_STUFF doubles as the "pending 0xFF" register: being in that state
    // means a 0xFF has been received and not yet appended.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_FETCH       = 2'd1,
        ST_FETCH_STUFF = 2'd2,
        ST_MARKER      = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] bit_reg_r;
    logic [5:0]  bit_cnt_r;
    logic        marker_r;
    logic [7:0]  marker_byte_r;
    logic        need_byte_r;

    logic [5:0]  n_raw_s;
    logic [5:0]  n_s;
    logic        rd_req_s;
    logic        spr_wr_s;
    logic        flush_s;
    logic        short_s;
    logic [5:0]  pad_s;
    logic [5:0]  consume_s;
    logic [31:0] rd_vec_s;
    logic        stall_s;
    logic        append_s;
    logic [7:0]  append_byte_s;
    logic [6:0]  cnt_sum_s;
    logic [5:0]  cnt_next_s;
    logic [31:0] reg_next_s;

    // Mask with the low k bits set; k may reach 32.
    function automatic logic [31:0] low_mask(input logic [5:0] k);
        if (k >= 6'd32) begin
            low_mask = 32'hFFFF_FFFF;
        end else begin
            low_mask = (32'd1 << k) - 32'd1;
        end
    endfunction

    assign n_raw_s  = {1'b0, num_bits_to_read_i};
    assign n_s      = (n_raw_s > MAX_READ_C) ? MAX_READ_C : n_raw_s;
    assign rd_req_s = get_bit_op_i && (n_s != 6'd0);
    assign spr_wr_s = write_dp_spr_i;
    assign flush_s  = write_dp_spr_i && !spr_addr && spr_dat_i[31];
    assign short_s  = (n_s > bit_cnt_r);

    // Combinational get-bits result, stall and number of bits consumed.
    always_comb begin
        rd_vec_s  = 32'd0;
        stall_s   = 1'b0;
        consume_s = 6'd0;
        pad_s     = 6'd0;
        if (rd_req_s) begin
            if (spr_wr_s) begin
                // SPR write owns this cycle; the CPU retries next cycle.
                stall_s = 1'b1;
            end else if (!short_s) begin
                rd_vec_s  = (bit_reg_r >> (bit_cnt_r - n_s)) & low_mask(n_s);
                consume_s = n_s;
            end else if (marker_r) begin
                // Segment ended: return what is left, padded with 1s.
                pad_s     = n_s - bit_cnt_r;
                rd_vec_s  = ((bit_reg_r & low_mask(bit_cnt_r)) << pad_s) | low_mask(pad_s);
                consume_s = bit_cnt_r;
            end else begin
                stall_s = 1'b1;
            end
        end else begin
            rd_vec_s = 32'd0;
            stall_s  = 1'b0;
        end
    end

    // Decide whether the acked byte enters the bit buffer, and with what value.
    always_comb begin
        append_s      = 1'b0;
        append_byte_s = 8'h00;
        case (state_r)
            ST_FETCH: begin
                if (ack_i && !spr_wr_s && (byte_i != 8'hFF)) begin
                    append_s      = 1'b1;
                    append_byte_s = byte_i;
                end else begin
                    append_s = 1'b0;
                end
            end
            ST_FETCH_STUFF: begin
                if (ack_i && !spr_wr_s && (byte_i == 8'h00)) begin
                    append_s      = 1'b1;
                    append_byte_s = 8'hFF;
                end else begin
                    append_s = 1'b0;
                end
            end
            default: begin
                append_s      = 1'b0;
                append_byte_s = 8'h00;
            end
        endcase
    end

    // Next bit buffer and bit count; SPR writes override reads and appends.
    always_comb begin
        cnt_sum_s = {1'b0, bit_cnt_r} - {1'b0, consume_s} + (append_s ? 7'd8 : 7'd0);
        if (spr_wr_s && spr_addr) begin
            reg_next_s = spr_dat_i;
            cnt_next_s = bit_cnt_r;
        end else if (spr_wr_s) begin
            reg_next_s = bit_reg_r;
            cnt_next_s = (spr_dat_i[5:0] > 6'd32) ? 6'd32 : spr_dat_i[5:0];
        end else begin
            reg_next_s = append_s ? {bit_reg_r[23:0], append_byte_s} : bit_reg_r;
            cnt_next_s = (cnt_sum_s > 7'd32) ? 6'd32 : cnt_sum_s[5:0];
        end
    end

    // Bit buffer and bit count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_reg_r <= 32'd0;
            bit_cnt_r <= 6'd0;
        end else begin
            bit_reg_r <= reg_next_s;
            bit_cnt_r <= cnt_next_s;
        end
    end

    // Fetch FSM with registered request and marker outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= ST_IDLE;
            need_byte_r   <= 1'b0;
            marker_r      <= 1'b0;
            marker_byte_r <= 8'h00;
        end else if (flush_s) begin
            state_r       <= ST_IDLE;
            need_byte_r   <= 1'b0;
            marker_r      <= 1'b0;
            marker_byte_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Fetch only while the post-edge count leaves room for a byte.
                    if ((cnt_next_s <= 6'd24) && !marker_r) begin
                        state_r     <= ST_FETCH;
                        need_byte_r <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        need_byte_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (ack_i && (spr_wr_s || (byte_i != 8'hFF))) begin
                        state_r     <= ST_IDLE;
                        need_byte_r <= 1'b0;
                    end else if (ack_i) begin
                        state_r     <= ST_FETCH_STUFF;
                        need_byte_r <= 1'b1;
                    end else begin
                        state_r     <= ST_FETCH;
                        need_byte_r <= 1'b1;
                    end
                end
                ST_FETCH_STUFF: begin
                    if (ack_i && (spr_wr_s || (byte_i == 8'h00))) begin
                        state_r     <= ST_IDLE;
                        need_byte_r <= 1'b0;
                    end else if (ack_i) begin
                        state_r       <= ST_MARKER;
                        need_byte_r   <= 1'b0;
                        marker_r      <= 1'b1;
                        marker_byte_r <= byte_i;
                    end else begin
                        state_r     <= ST_FETCH_STUFF;
                        need_byte_r <= 1'b1;
                    end
                end
                ST_MARKER: begin
                    state_r     <= ST_MARKER;
                    need_byte_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    need_byte_r <= 1'b0;
                end
            endcase
        end
    end

    assign need_byte_o   = need_byte_r;
    assign marker_o      = marker_r;
    assign marker_byte_o = marker_byte_r;
    assign bit_vector_o  = rd_vec_s;
    assign stall_CPU_o   = stall_s;
    assign spr_dat_o     = spr_addr ? bit_reg_r : {25'd0, marker_r, bit_cnt_r};

endmodule
